alu_seq_ctrl: RTL and testbench

Operand/opcode sequencer for the Basys3 6-bit ALU. Walks the user through entering operand A, an opcode and, for binary ops only, operand B from the slide switches, one step-button press per field. It drives the shared combinational ALU (add, sub, negate, logic units), waits a fixed settle time, then captures and holds the result and overflow flag for display. It sits between the board I/O (switches, buttons, LEDs) and the ALU datapath.

---
 rtl/alu_seq_ctrl_pkg.sv | 32 +++
 rtl/alu_seq_ctrl_if.sv | 32 +++
 rtl/alu_seq_ctrl_btn_sync.sv | 31 +++
 rtl/alu_seq_ctrl.sv | 117 +++++++++++
 tb/tb_alu_seq_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// alu_pkg: shared definitions for the ALU operand/opcode sequencer.
//   - opcode constants for the 6-bit board ALU
//   - FSM state encoding (also shown on the state LEDs)
//   - is_unary(): opcodes that take no B operand
package alu_pkg;

    localparam int WIDTH_DEF = 6;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_NEG  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_NOT  = 3'b110,
        OP_PASS = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_OP = 3'd1,
        ST_GET_B  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic is_unary(input logic [2:0] op);
        return (op == OP_NEG) || (op == OP_NOT) || (op == OP_PASS);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: board I/O + ALU datapath bundle for the sequencer.
//   sw, btn_step, btn_clear      : switches / debounced buttons
//   alu_a, alu_b, alu_op         : registered operands/opcode to the ALU
//   alu_result, alu_ovf          : combinational ALU response
//   result, ovf, result_valid    : captured result for display
//   busy, state_led              : status
// master = board/ALU side, slave = sequencer.
interface alu_seq_ctrl_if #(parameter int WIDTH = 6);
    logic [WIDTH-1:0] sw;
    logic             btn_step;
    logic             btn_clear;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             result_valid;
    logic             busy;
    logic [2:0]       state_led;

    modport master (
        output sw, btn_step, btn_clear, alu_result, alu_ovf,
        input  alu_a, alu_b, alu_op, result, ovf, result_valid, busy, state_led
    );

    modport slave (
        input  sw, btn_step, btn_clear, alu_result, alu_ovf,
        output alu_a, alu_b, alu_op, result, ovf, result_valid, busy, state_led
    );
endinterface

// File: rtl/alu_seq_ctrl_btn_sync.sv
// btn_sync_edge: brings an asynchronous debounced button into the clk domain.
//   clk, rst_n : clock, async active-low reset
//   btn        : raw (debounced) button
//   level      : synchronized level (registered)
//   rise       : one-cycle pulse on a synchronized rising edge
// The pulse is high in the cycle after the second sync flop goes high, so a
// consumer acts on the third rising edge after the button rises.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);
    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: steps the user through A, opcode and (binary ops only) B,
// drives the external combinational ALU, waits EXEC_WAIT cycles for it to
// settle, then captures result/overflow for display.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : switches/buttons in, ALU operands out, ALU result in,
//                  captured result/status out
// Clear is a level: while held the sequencer sits in GET_A with everything
// zeroed, and it wins over a step in the same cycle.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXEC_WAIT = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(EXEC_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_WAIT - 1);

    logic step, clr;
    logic step_lvl_unused, clr_rise_unused;

    btn_sync_edge u_step (
        .clk(clk), .rst_n(reset_n), .btn(bus.btn_step),
        .level(step_lvl_unused), .rise(step)
    );

    btn_sync_edge u_clear (
        .clk(clk), .rst_n(reset_n), .btn(bus.btn_clear),
        .level(clr), .rise(clr_rise_unused)
    );

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic             ovf_q, rv_q, busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_GET_A;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            rv_q   <= 1'b0;
            busy_q <= 1'b0;
        end else if (clr) begin
            state  <= ST_GET_A;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            rv_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                ST_GET_A: if (step) begin
                    a_q   <= bus.sw;
                    rv_q  <= 1'b0;
                    state <= ST_GET_OP;
                end
                ST_GET_OP: if (step) begin
                    op_q <= bus.sw[2:0];
                    if (is_unary(bus.sw[2:0])) begin
                        b_q    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_EXEC;
                    end else begin
                        state <= ST_GET_B;
                    end
                end
                ST_GET_B: if (step) begin
                    b_q    <= bus.sw;
                    cnt    <= '0;
                    busy_q <= 1'b1;
                    state  <= ST_EXEC;
                end
                // Step pulses arriving here are simply dropped.
                ST_EXEC: begin
                    if (cnt == CNT_LAST) begin
                        res_q  <= bus.alu_result;
                        ovf_q  <= bus.alu_ovf;
                        rv_q   <= 1'b1;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: if (step) state <= ST_GET_A;
                default: begin
                    state  <= ST_GET_A;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_op       = op_q;
    assign bus.result       = res_q;
    assign bus.ovf          = ovf_q;
    assign bus.result_valid = rv_q;
    assign bus.busy         = busy_q;
    assign bus.state_led    = state;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench: expected ALU results are pushed into a scoreboard queue as
// each operation is issued; a monitor pops and compares on every rising
// result_valid. Sequence/status checks are done inline.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int W  = 6;
    localparam int EW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.WIDTH(W)) bus();

    alu_seq_ctrl #(.WIDTH(W), .EXEC_WAIT(EW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // Reference combinational ALU.
    logic [W-1:0] alu_r;
    logic         alu_o;
    always_comb begin
        alu_r = '0;
        alu_o = 1'b0;
        case (bus.alu_op)
            3'b000: begin
                alu_r = bus.alu_a + bus.alu_b;
                alu_o = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (alu_r[W-1] != bus.alu_a[W-1]);
            end
            3'b001: begin
                alu_r = bus.alu_a - bus.alu_b;
                alu_o = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (alu_r[W-1] != bus.alu_a[W-1]);
            end
            3'b010: begin
                alu_r = -bus.alu_a;
                alu_o = (bus.alu_a == {1'b1, {(W-1){1'b0}}});
            end
            3'b011: alu_r = bus.alu_a & bus.alu_b;
            3'b100: alu_r = bus.alu_a | bus.alu_b;
            3'b101: alu_r = bus.alu_a ^ bus.alu_b;
            3'b110: alu_r = ~bus.alu_a;
            default: alu_r = bus.alu_a;
        endcase
    end
    assign bus.alu_result = alu_r;
    assign bus.alu_ovf    = alu_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W:0] exp_q[$];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    int   busy_cyc = 0;
    logic rv_d = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cyc = 0;
            rv_d     = 1'b0;
        end else begin
            if (bus.busy) busy_cyc++;
            if (bus.result_valid && !rv_d) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: result %0d with empty queue", bus.result);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    chk("sb_result", bus.result, e[W:1]);
                    chk("sb_ovf", bus.ovf, e[0]);
                    chk("busy_cycles", busy_cyc, EW);
                end
                busy_cyc = 0;
            end
            rv_d = bus.result_valid;
        end
    end

    // One step press: button held 'hold' cycles, then released long enough
    // for the synchronizer to see it low.
    task automatic step(input logic [W-1:0] v, input int hold = 3);
        @(negedge clk);
        bus.sw = v;
        bus.btn_step = 1'b1;
        repeat (hold) @(negedge clk);
        bus.btn_step = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.sw = '0;
        bus.btn_step = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", bus.state_led, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        reset_n = 1'b1;

        // ADD 5 + 3
        step(6'b000101);
        chk("add_get_op", bus.state_led, 1);
        chk("add_alu_a", bus.alu_a, 5);
        step(6'b000000);
        chk("add_get_b", bus.state_led, 2);
        exp_q.push_back({6'b001000, 1'b0});
        step(6'b000011);
        chk("add_done", bus.state_led, 4);
        chk("add_busy_low", bus.busy, 0);
        chk("add_alu_b", bus.alu_b, 3);

        step(6'b000000);
        chk("done_to_get_a", bus.state_led, 0);
        chk("rv_held_in_get_a", bus.result_valid, 1);

        // NEG 21 (unary, GET_B skipped)
        step(6'b010101);
        chk("rv_cleared_a_step", bus.result_valid, 0);
        exp_q.push_back({6'b101011, 1'b0});
        step(6'b000010);
        chk("neg_skips_get_b", bus.state_led, 4);
        chk("neg_alu_b_zero", bus.alu_b, 0);

        // SUB 31 - (-8) overflows
        step(6'b000000);
        step(6'b011111);
        step(6'b000001);
        exp_q.push_back({6'b100111, 1'b1});
        step(6'b111000);
        chk("sub_done", bus.state_led, 4);

        // Held step advances exactly once
        step(6'b000000, 100);
        chk("held_step_one_adv", bus.state_led, 0);
        chk("held_rv", bus.result_valid, 1);

        // Step pulse landing in EXEC is discarded: SUB 5 - 3
        step(6'b000101);
        step(6'b000001);
        exp_q.push_back({6'b000010, 1'b0});
        @(negedge clk); bus.sw = 6'b000011; bus.btn_step = 1'b1;
        @(negedge clk); bus.btn_step = 1'b0;
        @(negedge clk); bus.btn_step = 1'b1;
        @(negedge clk); bus.btn_step = 1'b0;
        repeat (6) @(negedge clk);
        chk("exec_step_discarded", bus.state_led, 4);
        chk("exec_step_rv", bus.result_valid, 1);

        // Clear and step together
        @(negedge clk);
        bus.btn_clear = 1'b1;
        bus.btn_step  = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_clear = 1'b0;
        bus.btn_step  = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_state", bus.state_led, 0);
        chk("clr_alu_a", bus.alu_a, 0);
        chk("clr_alu_b", bus.alu_b, 0);
        chk("clr_alu_op", bus.alu_op, 0);
        chk("clr_result", bus.result, 0);
        chk("clr_ovf", bus.ovf, 0);
        chk("clr_rv", bus.result_valid, 0);

        // NEG -32 overflows; then repeat operation
        step(6'b100000);
        exp_q.push_back({6'b100000, 1'b1});
        step(6'b000010);
        chk("neg32_done", bus.state_led, 4);
        step(6'b000000);
        chk("rpt_rv_still_1", bus.result_valid, 1);
        step(6'b000001);
        chk("rv_drops_at_a_step", bus.result_valid, 0);

        // Reset while in EXEC
        @(negedge clk);
        bus.sw = 6'b000010;
        bus.btn_step = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_exec_state", bus.state_led, 3);
        chk("mid_exec_busy", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_exec_state", bus.state_led, 0);
        chk("rst_exec_busy", bus.busy, 0);
        chk("rst_exec_alu_a", bus.alu_a, 0);
        chk("rst_exec_alu_op", bus.alu_op, 0);
        bus.btn_step = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        step(6'b000111);
        chk("post_rst_get_op", bus.state_led, 1);
        chk("post_rst_alu_a", bus.alu_a, 7);

        repeat (4) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
